// File: rtl/ft245_pkg.sv
// Shared types and defaults for the FT245-style FIFO responder.
package ft245_pkg;

    typedef logic [7:0] byte_t;

    // FPGA read strobe handling
    typedef enum logic [1:0] {
        RdIdle,
        RdDrive,
        RdPrecharge
    } rd_state_e;

    // FPGA write strobe handling
    typedef enum logic [1:0] {
        WrIdle,
        WrHold,
        WrPrecharge
    } wr_state_e;

    localparam int unsigned DEFAULT_DEPTH         = 16;
    localparam int unsigned DEFAULT_RXF_PRECHARGE = 2;
    localparam int unsigned DEFAULT_TXE_PRECHARGE = 2;
    localparam int unsigned CNT_W                 = 16;

endpackage

// File: rtl/byte_sync_fifo.sv
// Single-clock byte FIFO. Pointers carry one extra wrap bit, so full and
// empty are told apart without an occupancy counter. Push and pop are
// gated by the flags as they stand before this cycle's operations.
module byte_sync_fifo
    import ft245_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic  clk,
    input  logic  nRST,
    input  logic  push_i,
    input  byte_t wdata_i,
    input  logic  pop_i,
    output logic  full_o,
    output logic  empty_o,
    output byte_t head_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W:0] wptr_q, wptr_d, rptr_q, rptr_d;
    byte_t          mem_q [DEPTH];
    logic           do_push, do_pop;

    // Flags, gated operations and pointer advance
    always_comb begin
        empty_o = (wptr_q == rptr_q);
        full_o  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                  (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        wptr_d  = do_push ? wptr_q + (PTR_W + 1)'(1) : wptr_q;
        rptr_d  = do_pop  ? rptr_q + (PTR_W + 1)'(1) : rptr_q;
        head_o  = mem_q[rptr_q[PTR_W-1:0]];
    end

    // Pointer registers
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage; contents are meaningless until written, so no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[PTR_W-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/ft245_fifo_responder.sv
// Device-side FT245 FIFO bridge model: answers rd/wr strobes from the FPGA,
// feeds an RX FIFO from the host push port, drains a TX FIFO to the host
// pop port. Define FT245_ERR_CNT_EN to build the saturating overrun and
// underrun counters; otherwise ovr_cnt/udr_cnt are tied to zero.
module ft245_fifo_responder
    import ft245_pkg::*;
#(
    parameter int unsigned DEPTH         = DEFAULT_DEPTH,
    parameter int unsigned RXF_PRECHARGE = DEFAULT_RXF_PRECHARGE,
    parameter int unsigned TXE_PRECHARGE = DEFAULT_TXE_PRECHARGE
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic             rd,
    input  logic             wr,
    input  logic [7:0]       data_in,
    output logic [7:0]       data_out,
    output logic             data_oe,
    output logic             rxf,
    output logic             txe,
    input  logic [7:0]       host_wdata,
    input  logic             host_wvalid,
    output logic             host_wready,
    output logic [7:0]       host_rdata,
    output logic             host_rvalid,
    input  logic             host_rready,
    output logic [CNT_W-1:0] ovr_cnt,
    output logic [CNT_W-1:0] udr_cnt
);

    localparam int unsigned RX_CNT_W = (RXF_PRECHARGE > 0) ? $clog2(RXF_PRECHARGE + 1) : 1;
    localparam int unsigned TX_CNT_W = (TXE_PRECHARGE > 0) ? $clog2(TXE_PRECHARGE + 1) : 1;
    localparam logic [RX_CNT_W-1:0] RX_LOAD = RX_CNT_W'(RXF_PRECHARGE);
    localparam logic [TX_CNT_W-1:0] TX_LOAD = TX_CNT_W'(TXE_PRECHARGE);

    // Strobe samples: *_s_q is the current sample, *_p_q the previous one
    logic  rd_s_q, rd_p_q, wr_s_q, wr_p_q;
    byte_t din_q;
    logic  rd_fall, rd_rise, wr_fall, wr_rise;

    rd_state_e           rd_state_q, rd_state_d;
    wr_state_e           wr_state_q, wr_state_d;
    logic [RX_CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [TX_CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    byte_t               data_out_q, data_out_d;

    logic  rx_full, rx_empty, rx_pop;
    byte_t rx_head;
    logic  tx_full, tx_empty, tx_push;

    assign rd_fall = rd_p_q & ~rd_s_q;
    assign rd_rise = ~rd_p_q & rd_s_q;
    assign wr_fall = wr_p_q & ~wr_s_q;
    assign wr_rise = ~wr_p_q & wr_s_q;

    // Read side: pop on falling edge, drive until rising edge, then precharge
    always_comb begin
        rd_state_d = rd_state_q;
        rx_cnt_d   = rx_cnt_q;
        data_out_d = data_out_q;
        rx_pop     = 1'b0;
        unique case (rd_state_q)
            RdIdle: begin
                if (rd_fall) begin
                    rd_state_d = RdDrive;
                    if (!rx_empty) begin
                        rx_pop     = 1'b1;
                        data_out_d = rx_head;
                    end
                end
            end
            RdDrive: begin
                if (rd_rise) begin
                    if (RXF_PRECHARGE == 0) begin
                        rd_state_d = RdIdle;
                    end else begin
                        rd_state_d = RdPrecharge;
                        rx_cnt_d   = RX_LOAD;
                    end
                end
            end
            RdPrecharge: begin
                if (rx_cnt_q <= RX_CNT_W'(1)) begin
                    rd_state_d = RdIdle;
                    rx_cnt_d   = '0;
                end else begin
                    rx_cnt_d = rx_cnt_q - RX_CNT_W'(1);
                end
            end
            default: rd_state_d = RdIdle;
        endcase
    end

    // Write side: push registered data on falling edge, hold, then precharge
    always_comb begin
        wr_state_d = wr_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_push    = 1'b0;
        unique case (wr_state_q)
            WrIdle: begin
                if (wr_fall) begin
                    wr_state_d = WrHold;
                    tx_push    = !tx_full;
                end
            end
            WrHold: begin
                if (wr_rise) begin
                    if (TXE_PRECHARGE == 0) begin
                        wr_state_d = WrIdle;
                    end else begin
                        wr_state_d = WrPrecharge;
                        tx_cnt_d   = TX_LOAD;
                    end
                end
            end
            WrPrecharge: begin
                if (tx_cnt_q <= TX_CNT_W'(1)) begin
                    wr_state_d = WrIdle;
                    tx_cnt_d   = '0;
                end else begin
                    tx_cnt_d = tx_cnt_q - TX_CNT_W'(1);
                end
            end
            default: wr_state_d = WrIdle;
        endcase
    end

    // Strobe sampling and both FSMs' state
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            rd_s_q     <= 1'b1;
            rd_p_q     <= 1'b1;
            wr_s_q     <= 1'b1;
            wr_p_q     <= 1'b1;
            din_q      <= '0;
            rd_state_q <= RdIdle;
            wr_state_q <= WrIdle;
            rx_cnt_q   <= '0;
            tx_cnt_q   <= '0;
            data_out_q <= '0;
        end else begin
            rd_s_q     <= rd;
            rd_p_q     <= rd_s_q;
            wr_s_q     <= wr;
            wr_p_q     <= wr_s_q;
            din_q      <= data_in;
            rd_state_q <= rd_state_d;
            wr_state_q <= wr_state_d;
            rx_cnt_q   <= rx_cnt_d;
            tx_cnt_q   <= tx_cnt_d;
            data_out_q <= data_out_d;
        end
    end

    // Status decode from registered state only
    always_comb begin
        data_out    = data_out_q;
        data_oe     = (rd_state_q == RdDrive);
        rxf         = !(!rx_empty && (rx_cnt_q == '0) && (rd_state_q == RdIdle));
        txe         = !(!tx_full && (tx_cnt_q == '0) && (wr_state_q == WrIdle));
        host_wready = !rx_full;
        host_rvalid = !tx_empty;
    end

    byte_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .nRST    (nRST),
        .push_i  (host_wvalid && host_wready),
        .wdata_i (host_wdata),
        .pop_i   (rx_pop),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .head_o  (rx_head)
    );

    byte_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .nRST    (nRST),
        .push_i  (tx_push),
        .wdata_i (din_q),
        .pop_i   (host_rvalid && host_rready),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .head_o  (host_rdata)
    );

`ifdef FT245_ERR_CNT_EN
    logic [CNT_W-1:0] ovr_cnt_q, ovr_cnt_d, udr_cnt_q, udr_cnt_d;
    logic             ovr_evt, udr_evt;

    // Saturating error counters; events are the strobe edges that found no room/data
    always_comb begin
        ovr_evt   = (wr_state_q == WrIdle) && wr_fall && tx_full;
        udr_evt   = (rd_state_q == RdIdle) && rd_fall && rx_empty;
        ovr_cnt_d = ovr_cnt_q;
        udr_cnt_d = udr_cnt_q;
        if (ovr_evt && (ovr_cnt_q != '1)) ovr_cnt_d = ovr_cnt_q + CNT_W'(1);
        if (udr_evt && (udr_cnt_q != '1)) udr_cnt_d = udr_cnt_q + CNT_W'(1);
    end

    // Counter registers, cleared only by reset
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            ovr_cnt_q <= '0;
            udr_cnt_q <= '0;
        end else begin
            ovr_cnt_q <= ovr_cnt_d;
            udr_cnt_q <= udr_cnt_d;
        end
    end

    assign ovr_cnt = ovr_cnt_q;
    assign udr_cnt = udr_cnt_q;
`else
    assign ovr_cnt = '0;
    assign udr_cnt = '0;
`endif

endmodule

// File: tb/tb_ft245_fifo_responder.sv
// Randomised scoreboard bench for ft245_fifo_responder. Stimulus tasks update a
// queue-based model and push expected bytes; monitors compare on data_oe rise
// and on each host pop.
module tb_ft245_fifo_responder;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        nRST;
    logic        rd, wr;
    logic [7:0]  data_in, data_out;
    logic        data_oe, rxf, txe;
    logic [7:0]  host_wdata, host_rdata;
    logic        host_wvalid, host_wready, host_rvalid, host_rready;
    logic [15:0] ovr_cnt, udr_cnt;

    int          checks = 0;
    int          errors = 0;

    logic [7:0]  rx_model[$];
    logic [7:0]  rd_exp[$];
    logic [7:0]  tx_exp[$];
    logic [7:0]  last_rd;
    int          ovr_m, udr_m;
    logic        oe_prev;

    ft245_fifo_responder u_dut (
        .clk         (clk),
        .nRST        (nRST),
        .rd          (rd),
        .wr          (wr),
        .data_in     (data_in),
        .data_out    (data_out),
        .data_oe     (data_oe),
        .rxf         (rxf),
        .txe         (txe),
        .host_wdata  (host_wdata),
        .host_wvalid (host_wvalid),
        .host_wready (host_wready),
        .host_rdata  (host_rdata),
        .host_rvalid (host_rvalid),
        .host_rready (host_rready),
        .ovr_cnt     (ovr_cnt),
        .udr_cnt     (udr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
`ifdef FT245_ERR_CNT_EN
        return (n > 65535) ? 32'd65535 : 32'(n);
`else
        return (n > 65535) ? 32'd0 : 32'd0 + 32'(0 * n);
`endif
    endfunction

    // Scoreboard monitors: read data on data_oe rise, TX bytes on each host pop
    always @(negedge clk) begin : monitor
        logic [7:0] e;
        if (data_oe && !oe_prev) begin
            if (rd_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected got=%0h expected=none", data_out);
            end else begin
                e = rd_exp.pop_front();
                check("rd_data", {24'd0, data_out}, {24'd0, e});
            end
        end
        oe_prev = data_oe;
        if (nRST && host_rvalid && host_rready) begin
            if (tx_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected got=%0h expected=none", host_rdata);
            end else begin
                e = tx_exp.pop_front();
                check("tx_data", {24'd0, host_rdata}, {24'd0, e});
            end
        end
    end

    task automatic host_push(input logic [7:0] b);
        @(posedge clk); #1;
        host_wvalid = 1'b1;
        host_wdata  = b;
        @(negedge clk);
        check("host_wready", host_wready, rx_model.size() < DEPTH);
        if (rx_model.size() < DEPTH) rx_model.push_back(b);
        @(posedge clk); #1;
        host_wvalid = 1'b0;
        @(negedge clk);
        check("rxf_after_push", rxf, rx_model.size() == 0);
    endtask

    task automatic rd_pulse(input int low, input bit with_push, input logic [7:0] b);
        int pre;
        @(posedge clk); #1;
        rd  = 1'b0;
        pre = rx_model.size();
        if (pre > 0) last_rd = rx_model.pop_front();
        else udr_m++;
        rd_exp.push_back(last_rd);
        @(posedge clk); #1;
        if (with_push) begin
            host_wvalid = 1'b1;
            host_wdata  = b;
        end
        @(negedge clk);
        if (with_push) begin
            check("wready_concurrent", host_wready, pre < DEPTH);
            if (pre < DEPTH) rx_model.push_back(b);
        end
        @(posedge clk); #1;
        host_wvalid = 1'b0;
        check("oe_drive", data_oe, 1);
        check("rxf_drive", rxf, 1);
        repeat (low - 2) begin
            @(posedge clk); #1;
        end
        rd = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("oe_release", data_oe, 0);
        check("rxf_precharge", rxf, 1);
        @(posedge clk); @(negedge clk);
        check("rxf_precharge2", rxf, 1);
        @(posedge clk); @(negedge clk);
        check("rxf_idle", rxf, rx_model.size() == 0);
    endtask

    task automatic wr_pulse(input logic [7:0] b);
        @(posedge clk); #1;
        wr      = 1'b0;
        data_in = b;
        if (tx_exp.size() < DEPTH) tx_exp.push_back(b);
        else ovr_m++;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("txe_hold", txe, 1);
        wr = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("txe_precharge", txe, 1);
        @(posedge clk); @(negedge clk);
        check("txe_precharge2", txe, 1);
        @(posedge clk); @(negedge clk);
        check("txe_idle", txe, tx_exp.size() >= DEPTH);
    endtask

    task automatic drain_tx(input int n);
        @(posedge clk); #1;
        host_rready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        host_rready = 1'b0;
        @(negedge clk);
        check("tx_drained", host_rvalid, tx_exp.size() != 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        nRST = 1'b0; rd = 1'b1; wr = 1'b1; data_in = '0;
        host_wdata = '0; host_wvalid = 1'b0; host_rready = 1'b0;
        last_rd = '0; ovr_m = 0; udr_m = 0; oe_prev = 1'b0;
        #1;
        check("rst_rxf", rxf, 1);
        check("rst_txe", txe, 0);
        check("rst_data_out", data_out, 0);
        check("rst_data_oe", data_oe, 0);
        check("rst_wready", host_wready, 1);
        check("rst_rvalid", host_rvalid, 0);
        check("rst_ovr", ovr_cnt, 0);
        check("rst_udr", udr_cnt, 0);
        repeat (3) @(posedge clk);
        #1 nRST = 1'b1;

        // 1: single byte host->FPGA
        host_push(8'hA5);
        rd_pulse(4, 1'b0, 8'h00);

        // 2: four FPGA->host bytes
        for (int i = 0; i < 4; i++) wr_pulse(8'(i * 8'h11));
        check("tx_rvalid", host_rvalid, 1);
        drain_tx(4);

        // 3: overrun on the 17th push
        for (int i = 0; i < DEPTH + 1; i++) wr_pulse(8'($urandom));
        check("ovr_cnt", ovr_cnt, exp_cnt(ovr_m));
        drain_tx(DEPTH);

        // 4: underrun on empty RX
        rd_pulse(3, 1'b0, 8'h00);
        check("udr_cnt", udr_cnt, exp_cnt(udr_m));

        // 5: fill to 15, concurrent push/pop, then random mix with wrap
        for (int i = 0; i < DEPTH - 1; i++) host_push(8'($urandom));
        rd_pulse(3, 1'b1, 8'($urandom));
        check("occ15_not_full", host_wready, rx_model.size() < DEPTH);
        host_push(8'($urandom));
        check("rx_full", host_wready, rx_model.size() < DEPTH);
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0: host_push(8'($urandom));
                1: rd_pulse($urandom_range(2, 4), 1'b0, 8'h00);
                default: rd_pulse($urandom_range(2, 4), 1'b1, 8'($urandom));
            endcase
        end
        for (int i = 0; i < DEPTH && rx_model.size() > 0; i++) rd_pulse(2, 1'b0, 8'h00);
        check("udr_cnt_mix", udr_cnt, exp_cnt(udr_m));

        // 6: reset while in DRIVE
        host_push(8'h3C);
        host_push(8'hC3);
        wr_pulse(8'h77);
        wr_pulse(8'h88);
        @(posedge clk); #1;
        rd = 1'b0;
        last_rd = rx_model.pop_front();
        rd_exp.push_back(last_rd);
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        nRST = 1'b0;
        #1;
        check("rst_mid_oe", data_oe, 0);
        check("rst_mid_rxf", rxf, 1);
        rx_model.delete();
        tx_exp.delete();
        rd_exp.delete();
        ovr_m = 0; udr_m = 0; last_rd = '0;
        // The still-low rd after release reads as one falling edge on an empty FIFO
        udr_m = 1;
        rd_exp.push_back(8'h00);
        repeat (2) @(negedge clk);
        nRST = 1'b1;
        repeat (3) @(posedge clk);
        #1 rd = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("post_rst_oe", data_oe, 0);
        check("post_rst_rvalid", host_rvalid, 0);
        check("post_rst_wready", host_wready, 1);
        check("post_rst_rxf", rxf, 1);
        check("post_rst_txe", txe, 0);
        check("post_rst_udr", udr_cnt, exp_cnt(udr_m));
        check("post_rst_ovr", ovr_cnt, exp_cnt(ovr_m));
        check("rd_pending", rd_exp.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
